// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register organised as a two-entry skid buffer.
// The "main" entry drives the MEM-side outputs. The "skid" entry catches one
// extra entry while MEM stalls, so in_ready can be a pure register with no
// combinational path from out_ready.
// Optional feature: define EX_MEM_STALLCNT_EN to add the saturating stall_cnt
// port and its counter logic.
module ex_mem_stage #(
    parameter int WIDTH = 104
`ifdef EX_MEM_STALLCNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [4:0]       in_wsel,
    input  logic             in_wen,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [4:0]       out_wsel,
    output logic             out_wen,
    output logic [1:0]       occupancy
`ifdef EX_MEM_STALLCNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [4:0]       wsel;
        logic             wen;
    } entry_t;

    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    logic       main_valid_q, main_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic [1:0] occupancy_q, occupancy_d;

    entry_t in_entry;
    logic   accept;
    logic   drain;

    assign in_entry = '{data: in_data, wsel: in_wsel, wen: in_wen};
    assign accept   = in_valid & ~skid_valid_q;
    assign drain    = main_valid_q & out_ready;

    // Next-state selection for the main and skid entries. Flush takes precedence.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_d       = '0;
            skid_valid_d = 1'b0;
            skid_d       = '0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                // The older skid entry moves up first, which preserves order.
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
                skid_d       = '0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_d       = in_entry;
            end else begin
                // An empty main entry holds zeros, so outputs idle at zero.
                main_valid_d = 1'b0;
                main_d       = '0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = in_entry;
        end

        occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    // State registers for both entries and the occupancy count.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: the payload fields are cleared on reset along with the valid bits, so no stale entry can reach the outputs.
        if (RST) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            occupancy_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            occupancy_q  <= occupancy_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q.data & {WIDTH{main_valid_q}};
    assign out_wsel  = main_q.wsel & {5{main_valid_q}};
    assign out_wen   = main_q.wen & main_valid_q;
    assign occupancy = occupancy_q;

`ifdef EX_MEM_STALLCNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count cycles in which MEM refuses a presented entry. The count saturates
    // and is unaffected by flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed stimulus for ex_mem_stage. An order-preserving
// queue model (capacity 2) is compared against the outputs on every falling
// edge. Literal expectations are checked at known points in the sequence.
module tb_ex_mem_stage;

    localparam int WIDTH = 104;
`ifdef EX_MEM_STALLCNT_EN
    localparam int CNT_W     = 4;
    localparam int STALL_MAX = (1 << CNT_W) - 1;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [4:0]       ws;
        logic             we;
    } ent_t;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [4:0]       in_wsel = '0;
    logic             in_wen = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [4:0]       out_wsel;
    logic             out_wen;
    logic [1:0]       occupancy;
`ifdef EX_MEM_STALLCNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit cmp_en   = 1'b0;

    ex_mem_stage #(
        .WIDTH(WIDTH)
`ifdef EX_MEM_STALLCNT_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_wsel  (in_wsel),
        .in_wen   (in_wen),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_wsel (out_wsel),
        .out_wen  (out_wen),
        .occupancy(occupancy)
`ifdef EX_MEM_STALLCNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // The stage behaves as a FIFO of depth 2. It is ready whenever it is not full,
    // and it pops the head when MEM is ready.
    ent_t mq[$];
    int   m_stall = 0;

    always @(posedge CLK or posedge RST) begin
        int   n;
        bit   acc;
        ent_t e;
        if (RST) begin
            mq.delete();
            m_stall = 0;
        end else begin
            n   = mq.size();
            acc = in_valid && (n < 2);
`ifdef EX_MEM_STALLCNT_EN
            if (n > 0 && !out_ready && m_stall < STALL_MAX) m_stall = m_stall + 1;
`endif
            if (flush) begin
                mq.delete();
            end else begin
                if (n > 0 && out_ready) void'(mq.pop_front());
                if (acc) begin
                    e = {in_data, in_wsel, in_wen};
                    mq.push_back(e);
                end
            end
        end
    end

    // Compare the DUT outputs against the model on every falling edge.
    always @(negedge CLK) begin
        ent_t h;
        if (cmp_en) begin
            h = (mq.size() > 0) ? mq[0] : '0;
            check("m_out_valid", 128'(out_valid), 128'(mq.size() > 0));
            check("m_out_data", 128'(out_data), 128'(h.d));
            check("m_out_wsel", 128'(out_wsel), 128'(h.ws));
            check("m_out_wen", 128'(out_wen), 128'(h.we));
            check("m_in_ready", 128'(in_ready), 128'(mq.size() < 2));
            check("m_occupancy", 128'(occupancy), 128'(mq.size()));
`ifdef EX_MEM_STALLCNT_EN
            check("m_stall_cnt", 128'(stall_cnt), 128'(m_stall));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input logic [4:0] ws,
                         input bit we, input bit ordy, input bit fl);
        in_valid  = v;
        in_data   = d;
        in_wsel   = ws;
        in_wen    = we;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset
        #2 RST = 1'b1;
        #1 cmp_en = 1'b1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_occupancy", 128'(occupancy), 128'd0);
        step();
        step();
        check("rst_in_ready_hold", 128'(in_ready), 128'd1);
        RST = 1'b0;

        // One-cycle latency from accept to out_valid
        drive(1, 104'h5, 5'd3, 1, 1, 0);
        step();
        check("lat_out_valid", 128'(out_valid), 128'd1);
        check("lat_out_data", 128'(out_data), 128'h5);
        check("lat_out_wsel", 128'(out_wsel), 128'd3);
        check("lat_out_wen", 128'(out_wen), 128'd1);
        check("lat_occupancy", 128'(occupancy), 128'd1);
        drive(0, '0, '0, 0, 1, 0);
        step();
        check("idle_out_valid", 128'(out_valid), 128'd0);
        check("idle_out_data", 128'(out_data), 128'd0);
        check("idle_out_wen", 128'(out_wen), 128'd0);

        // Backpressure: fill both entries, then drain them in order
        drive(1, 104'h1, 5'd1, 1, 0, 0);
        step();
        drive(1, 104'h2, 5'd2, 0, 0, 0);
        step();
        check("bp_occupancy", 128'(occupancy), 128'd2);
        check("bp_in_ready", 128'(in_ready), 128'd0);
        check("bp_head_a", 128'(out_data), 128'h1);
        drive(1, 104'h77, 5'd7, 1, 0, 0);   // ignored: stage is full
        step();
        check("full_ignore_occ", 128'(occupancy), 128'd2);
        check("full_ignore_head", 128'(out_data), 128'h1);
        drive(0, '0, '0, 0, 1, 0);
        step();
        check("bp_head_b", 128'(out_data), 128'h2);
        check("bp_b_wsel", 128'(out_wsel), 128'd2);
        check("bp_b_wen", 128'(out_wen), 128'd0);
        check("bp_in_ready_after", 128'(in_ready), 128'd1);
        check("bp_occ_after", 128'(occupancy), 128'd1);
        step();
        check("bp_empty", 128'(out_valid), 128'd0);

        // Flush with two entries held and an incoming entry
        drive(1, 104'hA, 5'd10, 1, 0, 0);
        step();
        drive(1, 104'hB, 5'd11, 1, 0, 0);
        step();
        drive(1, 104'h3, 5'd4, 1, 0, 1);
        step();
        check("fl_out_valid", 128'(out_valid), 128'd0);
        check("fl_out_data", 128'(out_data), 128'd0);
        check("fl_out_wen", 128'(out_wen), 128'd0);
        check("fl_occupancy", 128'(occupancy), 128'd0);
        check("fl_in_ready", 128'(in_ready), 128'd1);
        drive(0, '0, '0, 0, 1, 0);
        step();
        check("fl_no_ghost", 128'(out_valid), 128'd0);

        // Drain and flush in the same cycle
        drive(1, 104'hC, 5'd12, 1, 0, 0);
        step();
        drive(0, '0, '0, 0, 1, 1);
        step();
        check("drfl_occupancy", 128'(occupancy), 128'd0);
        check("drfl_out_valid", 128'(out_valid), 128'd0);

        // Steady stream: accept and drain together every cycle
        for (int i = 16; i < 32; i++) begin
            drive(1, WIDTH'(i), 5'(i), i[0], 1, 0);
            step();
            check("stream_data", 128'(out_data), 128'(i));
            check("stream_occ", 128'(occupancy), 128'd1);
        end
        drive(0, '0, '0, 0, 1, 0);
        step();
        check("stream_end", 128'(out_valid), 128'd0);

        // Long stall of a single entry, with the counter saturating when enabled
        drive(1, 104'h55, 5'd5, 1, 0, 0);
        step();
        drive(0, '0, '0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step();
        check("stall_occ", 128'(occupancy), 128'd1);
        check("stall_head", 128'(out_data), 128'h55);
`ifdef EX_MEM_STALLCNT_EN
        check("stall_saturated", 128'(stall_cnt), 128'd15);
`endif

        // Reset asserted mid-transfer
        drive(1, 104'h66, 5'd6, 1, 0, 0);
        step();
        check("pre_rst_occ", 128'(occupancy), 128'd2);
        RST = 1'b1;
        #1;
        check("mrst_out_valid", 128'(out_valid), 128'd0);
        check("mrst_out_data", 128'(out_data), 128'd0);
        check("mrst_occupancy", 128'(occupancy), 128'd0);
        check("mrst_in_ready", 128'(in_ready), 128'd1);
`ifdef EX_MEM_STALLCNT_EN
        check("mrst_stall_cnt", 128'(stall_cnt), 128'd0);
`endif
        drive(1, 104'h99, 5'd9, 1, 1, 0);
        step();
        drive(0, '0, '0, 0, 1, 0);
        RST = 1'b0;
        step();
        check("post_rst_empty", 128'(out_valid), 128'd0);
        step();
        check("post_rst_empty2", 128'(out_valid), 128'd0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 104, payload bits carried per entry (all EX/MEM data and control except write-back select/enable).
REQ-002 SHALL have parameter CNT_W, default 32, width of the stall counter (exists only with EX_MEM_STALLCNT_EN).
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 flush  in  1  discard all held and incoming entries.
REQ-006 in_valid  in  1  upstream (EX) entry present.
REQ-007 in_ready  out  1  stage can accept an entry this cycle.
REQ-008 in_data  in  WIDTH  upstream payload.
REQ-009 in_wsel  in  5  destination register index.
REQ-010 in_wen  in  1  register write enable.
REQ-011 out_valid  out  1  head entry present toward MEM.
REQ-012 out_ready  in  1  MEM consumes head entry this cycle (iHit/dHit-derived).
REQ-013 out_data  out  WIDTH  head payload.
REQ-014 out_wsel  out  5  head destination index.
REQ-015 out_wen  out  1  head write enable, gated by out_valid.
REQ-016 occupancy  out  2  entries held (0, 1 or 2).
REQ-017 stall_cnt  out  CNT_W  backpressure cycle count (EX_MEM_STALLCNT_EN only).

Function
REQ-018 SHALL hold two entries: main (drives out_*) and skid; each with a valid bit.
REQ-019 in_ready SHALL equal NOT skid_valid, a registered value with no combinational path from out_ready.
REQ-020 Accept = in_valid AND in_ready; drain = out_valid AND out_ready.
REQ-021 Main empty or draining: main SHALL load skid if skid valid (skid empties), else load input if accept, else become empty.
REQ-022 Main full and not draining with accept: input SHALL load skid.
REQ-023 Latency SHALL be one cycle from accept to out_valid when main empty or draining.
REQ-024 Order SHALL be preserved; no entry dropped or duplicated absent flush.
REQ-025 out_data, out_wsel, out_wen SHALL be all zero whenever out_valid is 0.
REQ-026 flush SHALL take priority over all other events: at the next edge both valid bits and all held fields clear; any entry accepted in that cycle is discarded.
REQ-027 drain and flush in same cycle: entry counts as consumed by MEM; stage still ends empty.
REQ-028 Accept and drain simultaneously with skid empty: main replaced by input, occupancy unchanged.
REQ-029 Accept while skid full is impossible (in_ready=0); in_valid SHALL be ignored.
REQ-030 occupancy SHALL equal main_valid + skid_valid, registered.

Reset
REQ-031 RST high SHALL immediately clear both valid bits, all held fields, occupancy and stall_cnt; out_* = 0, out_valid = 0.
REQ-032 in_ready SHALL be 1 during and after reset.
REQ-033 RST asserted mid-transfer SHALL discard all entries; no partial entry emerges after release.

Configuration
REQ-034 Macro EX_MEM_STALLCNT_EN defined: stall_cnt port exists, increments by 1 each cycle out_valid=1 and out_ready=0, saturates at 2^CNT_W-1, unaffected by flush.
REQ-035 Macro EX_MEM_STALLCNT_EN undefined: stall_cnt port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-036 Reset then in_valid=1, in_data=0x5, in_wsel=3, in_wen=1, out_ready=1 -> next cycle out_valid=1, out_data=0x5, out_wsel=3, out_wen=1, occupancy=1.
REQ-037 out_ready=0, push A=0x1, B=0x2 back-to-back -> occupancy=2, in_ready=0; raise out_ready -> A then B on consecutive cycles, in_ready=1 after A drains.
REQ-038 Two entries held, flush=1 with in_valid=1 data 0x3 -> next cycle out_valid=0, out_data=0, out_wen=0, occupancy=0, 0x3 never appears.
REQ-039 Steady stream 0x10..0x1F with out_ready=1 -> one output per cycle, order kept, occupancy=1 throughout.
REQ-040 EX_MEM_STALLCNT_EN, CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); RST asserted mid-stream -> stall_cnt=0, out_valid=0 immediately.
